// File: rtl/riscv_pipe_pkg.sv
// Shared types and constants for the RV32I pipeline hazard unit.
// Provides register addressing, scoreboard counter sizing and the hazard action encoding.
package riscv_pipe_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;
  localparam int CNT_W      = 2;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  typedef enum logic [1:0] {
    HZ_NONE,
    HZ_RAW,
    HZ_REDIRECT,
    HZ_FREEZE
  } hazard_act_e;

  // A register is still pending unless its last in-flight writer retires this very cycle.
  function automatic logic pend_calc(input logic [CNT_W-1:0] cnt, input logic retire_hit);
    return (cnt != '0) && !((cnt == CNT_W'(1)) && retire_hit);
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline <-> hazard unit signal bundle.
// master = pipeline side (drives ID/EX/WB status), slave = hazard unit (drives stall/flush).
interface hazard_ctrl_if;
  import riscv_pipe_pkg::*;

  logic      id_valid;
  reg_addr_t id_rs1;
  reg_addr_t id_rs2;
  logic      id_use_rs1;
  logic      id_use_rs2;
  reg_addr_t id_rd;
  logic      id_regwrite;
  logic      ex_redirect;
  logic      ext_stall;
  logic      wb_valid;
  logic      wb_regwrite;
  reg_addr_t wb_rd;

  logic      pc_stall;
  logic      if_id_stall;
  logic      if_id_flush;
  logic      id_ex_stall;
  logic      id_ex_flush;
  logic      busy;

  modport master (
    output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd, id_regwrite,
    output ex_redirect, ext_stall, wb_valid, wb_regwrite, wb_rd,
    input  pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, busy
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd, id_regwrite,
    input  ex_redirect, ext_stall, wb_valid, wb_regwrite, wb_rd,
    output pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, busy
  );

endinterface

// File: rtl/hazard_ctrl_scoreboard.sv
// Per-register pending-write counters: +1 on issue, -1 on retire, saturating/holding at the rails.
// Answers "is this source still pending" for the two ID read ports.
module hazard_scoreboard
  import riscv_pipe_pkg::*;
(
  input  logic      i_clk,
  input  logic      i_reset_n,
  input  logic      i_issue,
  input  reg_addr_t i_issue_rd,
  input  logic      i_retire,
  input  reg_addr_t i_retire_rd,
  input  reg_addr_t i_rs1,
  input  reg_addr_t i_rs2,
  output logic      o_pend_rs1,
  output logic      o_pend_rs2,
  output logic      o_busy
);

  logic [NUM_REGS-1:0][CNT_W-1:0] cnt_reg;
  logic [NUM_REGS-1:0][CNT_W-1:0] cnt_next;

  generate
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_cnt
      if (gi == 0) begin : g_x0
        assign cnt_next[gi] = '0;
      end else begin : g_xn
        logic inc;
        logic dec;
        logic full;
        logic empty;

        assign inc   = i_issue  && (i_issue_rd  == REG_ADDR_W'(gi));
        assign dec   = i_retire && (i_retire_rd == REG_ADDR_W'(gi));
        assign full  = (cnt_reg[gi] == CNT_MAX);
        assign empty = (cnt_reg[gi] == '0);

        assign cnt_next[gi] = (inc && !dec && !full)  ? cnt_reg[gi] + CNT_W'(1) :
                              (dec && !inc && !empty) ? cnt_reg[gi] - CNT_W'(1) :
                                                        cnt_reg[gi];

        always_ff @(posedge i_clk) begin
          if (i_reset_n) begin
            assert (!(inc && !dec && full))
              else $error("hazard_scoreboard: overflow on x%0d", gi);
            assert (!(dec && !inc && empty))
              else $error("hazard_scoreboard: underflow on x%0d", gi);
          end
        end
      end
    end
  endgenerate

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

  assign o_pend_rs1 = (i_rs1 != '0) && pend_calc(cnt_reg[i_rs1], i_retire && (i_retire_rd == i_rs1));
  assign o_pend_rs2 = (i_rs2 != '0) && pend_calc(cnt_reg[i_rs2], i_retire && (i_retire_rd == i_rs2));
  assign o_busy     = |cnt_reg;

endmodule

// File: rtl/hazard_ctrl.sv
// Stall/flush resolver for the non-forwarding 5-stage RV32I pipeline (freeze > redirect > RAW).
// Optional perf counters enabled by defining HAZARD_PERF_CNT_EN.
module hazard_ctrl
  import riscv_pipe_pkg::*;
#(
  parameter int PERF_W = 32
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  hazard_ctrl_if.slave      hz,
  output logic [PERF_W-1:0] o_stall_cnt,
  output logic [PERF_W-1:0] o_flush_cnt
);

  logic        retire;
  logic        issue;
  logic        raw;
  logic        pend_rs1;
  logic        pend_rs2;
  logic        sb_busy;
  hazard_act_e act;

  assign retire = hz.wb_valid && hz.wb_regwrite && (hz.wb_rd != '0);
  assign raw    = hz.id_valid && ((hz.id_use_rs1 && pend_rs1) || (hz.id_use_rs2 && pend_rs2));

  always_comb begin
    act = HZ_NONE;
    if (hz.ext_stall) begin
      act = HZ_FREEZE;
    end else if (hz.ex_redirect) begin
      act = HZ_REDIRECT;
    end else if (raw) begin
      act = HZ_RAW;
    end
  end

  // HZ_NONE already excludes freeze, redirect and RAW.
  assign issue = hz.id_valid && hz.id_regwrite && (hz.id_rd != '0) && (act == HZ_NONE);

  hazard_scoreboard u_sb (
    .i_clk       (i_clk),
    .i_reset_n   (i_reset_n),
    .i_issue     (issue),
    .i_issue_rd  (hz.id_rd),
    .i_retire    (retire),
    .i_retire_rd (hz.wb_rd),
    .i_rs1       (hz.id_rs1),
    .i_rs2       (hz.id_rs2),
    .o_pend_rs1  (pend_rs1),
    .o_pend_rs2  (pend_rs2),
    .o_busy      (sb_busy)
  );

  always_comb begin
    hz.pc_stall    = 1'b0;
    hz.if_id_stall = 1'b0;
    hz.if_id_flush = 1'b0;
    hz.id_ex_stall = 1'b0;
    hz.id_ex_flush = 1'b0;
    if (i_reset_n) begin
      case (act)
        HZ_FREEZE: begin
          hz.pc_stall    = 1'b1;
          hz.if_id_stall = 1'b1;
          hz.id_ex_stall = 1'b1;
        end
        HZ_REDIRECT: begin
          hz.if_id_flush = 1'b1;
          hz.id_ex_flush = 1'b1;
        end
        HZ_RAW: begin
          hz.pc_stall    = 1'b1;
          hz.if_id_stall = 1'b1;
          hz.id_ex_flush = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign hz.busy = i_reset_n && sb_busy;

`ifdef HAZARD_PERF_CNT_EN
  logic [PERF_W-1:0] stall_cnt_reg;
  logic [PERF_W-1:0] flush_cnt_reg;

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      stall_cnt_reg <= '0;
      flush_cnt_reg <= '0;
    end else begin
      if (act == HZ_RAW)      stall_cnt_reg <= stall_cnt_reg + PERF_W'(1);
      if (act == HZ_REDIRECT) flush_cnt_reg <= flush_cnt_reg + PERF_W'(1);
    end
  end

  assign o_stall_cnt = i_reset_n ? stall_cnt_reg : '0;
  assign o_flush_cnt = i_reset_n ? flush_cnt_reg : '0;
`else
  assign o_stall_cnt = '0;
  assign o_flush_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: stimulus pushes hand-computed expectations, a negedge monitor checks them.
module tb_hazard_ctrl;

  localparam int PERF_W = 32;
`ifdef HAZARD_PERF_CNT_EN
  localparam bit PERF_EN = 1'b1;
`else
  localparam bit PERF_EN = 1'b0;
`endif

  // ctl = {pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, busy}
  localparam logic [5:0] NONE   = 6'b000000;
  localparam logic [5:0] NONE_B = 6'b000001;
  localparam logic [5:0] RAW_B  = 6'b110011;
  localparam logic [5:0] RED_B  = 6'b001011;
  localparam logic [5:0] FRZ_B  = 6'b110101;

  typedef struct packed {
    logic [5:0]        ctl;
    logic [PERF_W-1:0] scnt;
    logic [PERF_W-1:0] fcnt;
  } exp_t;

  logic              i_clk = 1'b0;
  logic              i_reset_n = 1'b0;
  logic [PERF_W-1:0] o_stall_cnt;
  logic [PERF_W-1:0] o_flush_cnt;

  hazard_ctrl_if hz ();

  hazard_ctrl #(.PERF_W(PERF_W)) dut (
    .i_clk       (i_clk),
    .i_reset_n   (i_reset_n),
    .hz          (hz.slave),
    .o_stall_cnt (o_stall_cnt),
    .o_flush_cnt (o_flush_cnt)
  );

  always #5 i_clk = ~i_clk;

  exp_t  exp_q[$];
  string name_q[$];
  int    checks = 0;
  int    errors = 0;
  int    m_scnt = 0;
  int    m_fcnt = 0;

  task automatic step(input string nm, input bit rn, input bit idv,
                      input int rs1, input bit u1, input int rs2, input bit u2,
                      input int rd, input bit rw, input bit redir, input bit xs,
                      input bit wbv, input int wrd, input logic [5:0] exp_ctl);
    exp_t e;
    i_reset_n      = rn;
    hz.id_valid    = idv;
    hz.id_rs1      = 5'(rs1);
    hz.id_use_rs1  = u1;
    hz.id_rs2      = 5'(rs2);
    hz.id_use_rs2  = u2;
    hz.id_rd       = 5'(rd);
    hz.id_regwrite = rw;
    hz.ex_redirect = redir;
    hz.ext_stall   = xs;
    hz.wb_valid    = wbv;
    hz.wb_regwrite = wbv;
    hz.wb_rd       = 5'(wrd);
    e.ctl  = exp_ctl;
    e.scnt = (PERF_EN && rn) ? PERF_W'(m_scnt) : '0;
    e.fcnt = (PERF_EN && rn) ? PERF_W'(m_fcnt) : '0;
    exp_q.push_back(e);
    name_q.push_back(nm);
    if (!rn) begin
      m_scnt = 0;
      m_fcnt = 0;
    end else if (exp_ctl[3]) begin
      m_fcnt++;
    end else if (exp_ctl[1] && !exp_ctl[2]) begin
      m_scnt++;
    end
    @(posedge i_clk);
    #1;
  endtask

  // Monitor: the DUT presents a control vector every cycle; compare mid-cycle.
  initial begin
    forever begin
      @(negedge i_clk);
      if (exp_q.size() > 0) begin
        exp_t  e;
        exp_t  a;
        string nm;
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        a.ctl  = {hz.pc_stall, hz.if_id_stall, hz.if_id_flush, hz.id_ex_stall, hz.id_ex_flush, hz.busy};
        a.scnt = o_stall_cnt;
        a.fcnt = o_flush_cnt;
        checks++;
        if (a !== e) begin
          errors++;
          $display("FAIL %s got ctl=%b scnt=%0d fcnt=%0d expected ctl=%b scnt=%0d fcnt=%0d",
                   nm, a.ctl, a.scnt, a.fcnt, e.ctl, e.scnt, e.fcnt);
        end else begin
          $display("ok   %s ctl=%b scnt=%0d fcnt=%0d", nm, a.ctl, a.scnt, a.fcnt);
        end
      end
    end
  end

  initial begin
    hz.id_valid = 0; hz.id_rs1 = 0; hz.id_rs2 = 0; hz.id_use_rs1 = 0; hz.id_use_rs2 = 0;
    hz.id_rd = 0; hz.id_regwrite = 0; hz.ex_redirect = 0; hz.ext_stall = 0;
    hz.wb_valid = 0; hz.wb_regwrite = 0; hz.wb_rd = 0;
    @(posedge i_clk);
    #1;
    //     name        rn idv rs1 u1 rs2 u2 rd rw red xs wbv wrd exp
    step("rst0",      0, 1,  5, 1,  0, 0,  6, 1, 1, 0, 1,  5, NONE);
    step("rst1",      0, 1,  0, 0,  0, 0,  9, 1, 0, 1, 0,  0, NONE);
    // RAW on x5 held until x5 retires
    step("t1_iss5",   1, 1,  0, 0,  0, 0,  5, 1, 0, 0, 0,  0, NONE);
    step("t1_raw0",   1, 1,  5, 1,  0, 0,  6, 1, 0, 0, 0,  0, RAW_B);
    step("t1_raw1",   1, 1,  5, 1,  0, 0,  6, 1, 0, 0, 0,  0, RAW_B);
    step("t1_raw2",   1, 1,  5, 1,  0, 0,  6, 1, 0, 0, 0,  0, RAW_B);
    step("t1_rel",    1, 1,  5, 1,  0, 0,  6, 1, 0, 0, 1,  5, NONE_B);
    step("t1_wb6",    1, 0,  0, 0,  0, 0,  0, 0, 0, 0, 1,  6, NONE_B);
    step("t1_idle",   1, 0,  0, 0,  0, 0,  0, 0, 0, 0, 0,  0, NONE);
    // x0 never tracked
    step("t2_w0",     1, 1,  0, 0,  0, 0,  0, 1, 0, 0, 0,  0, NONE);
    step("t2_r0",     1, 1,  0, 1,  0, 1,  0, 0, 0, 0, 0,  0, NONE);
    step("t2_idle",   1, 0,  0, 0,  0, 0,  0, 0, 0, 0, 0,  0, NONE);
    // redirect beats RAW, ID not issued
    step("t3_iss9",   1, 1,  0, 0,  0, 0,  9, 1, 0, 0, 0,  0, NONE);
    step("t3_red",    1, 1,  9, 1,  0, 0, 10, 1, 1, 0, 0,  0, RED_B);
    step("t3_wb9",    1, 0,  0, 0,  0, 0,  0, 0, 0, 0, 1,  9, NONE_B);
    step("t3_idle",   1, 0,  0, 0,  0, 0,  0, 0, 0, 0, 0,  0, NONE);
    // freeze beats everything, retire still honoured
    step("t4_iss7",   1, 1,  0, 0,  0, 0,  7, 1, 0, 0, 0,  0, NONE);
    step("t4_iss8",   1, 1,  0, 0,  0, 0,  8, 1, 0, 0, 0,  0, NONE_B);
    step("t4_frz",    1, 1,  0, 0,  8, 1, 11, 1, 1, 1, 1,  7, FRZ_B);
    step("t4_rd7",    1, 1,  0, 0,  7, 1,  0, 0, 0, 0, 0,  0, NONE_B);
    step("t4_wb8",    1, 0,  0, 0,  0, 0,  0, 0, 0, 0, 1,  8, NONE_B);
    step("t4_idle",   1, 0,  0, 0,  0, 0,  0, 0, 0, 0, 0,  0, NONE);
    // three writers of x3, issue+retire holds at 3
    step("t5_i1",     1, 1,  0, 0,  0, 0,  3, 1, 0, 0, 0,  0, NONE);
    step("t5_i2",     1, 1,  0, 0,  0, 0,  3, 1, 0, 0, 0,  0, NONE_B);
    step("t5_i3",     1, 1,  0, 0,  0, 0,  3, 1, 0, 0, 0,  0, NONE_B);
    step("t5_iwb",    1, 1,  0, 0,  0, 0,  3, 1, 0, 0, 1,  3, NONE_B);
    step("t5_r3a",    1, 1,  3, 1,  0, 0,  0, 0, 0, 0, 1,  3, RAW_B);
    step("t5_r3b",    1, 1,  3, 1,  0, 0,  0, 0, 0, 0, 1,  3, RAW_B);
    step("t5_r3c",    1, 1,  3, 1,  0, 0,  0, 0, 0, 0, 1,  3, NONE_B);
    step("t5_idle",   1, 0,  0, 0,  0, 0,  0, 0, 0, 0, 0,  0, NONE);
    // reset with x4 pending, then perf sequence
    step("t6_i4a",    1, 1,  0, 0,  0, 0,  4, 1, 0, 0, 0,  0, NONE);
    step("t6_i4b",    1, 1,  0, 0,  0, 0,  4, 1, 0, 0, 0,  0, NONE_B);
    step("t6_rst",    0, 0,  0, 0,  0, 0,  0, 0, 0, 0, 0,  0, NONE);
    step("t6_post",   1, 0,  0, 0,  0, 0,  0, 0, 0, 0, 0,  0, NONE);
    step("t6_i12",    1, 1,  0, 0,  0, 0, 12, 1, 0, 0, 0,  0, NONE);
    step("t6_raw0",   1, 1,  0, 0, 12, 1, 13, 1, 0, 0, 0,  0, RAW_B);
    step("t6_raw1",   1, 1,  0, 0, 12, 1, 13, 1, 0, 0, 0,  0, RAW_B);
    step("t6_raw2",   1, 1,  0, 0, 12, 1, 13, 1, 0, 0, 0,  0, RAW_B);
    step("t6_raw3",   1, 1,  0, 0, 12, 1, 13, 1, 0, 0, 0,  0, RAW_B);
    step("t6_red",    1, 1,  0, 0, 12, 1, 13, 1, 1, 0, 1, 12, RED_B);
    step("t6_idle",   1, 0,  0, 0,  0, 0,  0, 0, 0, 0, 0,  0, NONE);
    step("t6_idle2",  1, 0,  0, 0,  0, 0,  0, 0, 0, 0, 0,  0, NONE);

    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(posedge i_clk);
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain got %0d pending expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
